// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, handler address and
// SR/Cause field packing used by the register read mux.
package cp0_defs;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  // SR and Cause field positions
  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int SR_IM_LSB    = 10;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_BD_BIT  = 31;

  function automatic logic [31:0] sr_word(input logic [5:0] im, input logic exl,
                                          input logic ie);
    return {16'b0, im, 8'b0, exl, ie};
  endfunction

  function automatic logic [31:0] cause_word(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] exc_code);
    return {bd, 15'b0, ip, 3'b0, exc_code, 2'b00};
  endfunction

endpackage

// File: rtl/cp0.sv
// M-stage coprocessor 0: SR/Cause/EPC/PRId, interrupt/exception arbitration, Req.
// DOut/Req are combinational from current state; all register updates land on the next edge.
module cp0
  import cp0_defs::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h2023_0007,
  parameter logic [5:0]  IM_RESET = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] DOut,
  output logic [31:0] EPCOut,
  output logic        Req
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] trap_pc;

  // EXL masks both sources, so nothing nests while a handler runs
  assign int_req = ie_q & ~exl_q & (|(HWInt & im_q));
  assign exc_req = ~exl_q & (ExcCodeIn != 5'd0);
  assign Req     = int_req | exc_req;

  assign trap_pc = BDIn ? (PC - 32'd4) : PC;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = HWInt;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (Req) begin
      // the faulting instruction is flushed, so its mtc0 never commits
      exl_d      = 1'b1;
      bd_d       = BDIn;
      exc_code_d = int_req ? EXC_INT : ExcCodeIn;
      epc_d      = {trap_pc[31:2], 2'b00};
    end else begin
      if (WE && A2 == REG_SR) begin
        im_d  = DIn[SR_IM_LSB +: 6];
        exl_d = DIn[SR_EXL_BIT];
        ie_d  = DIn[SR_IE_BIT];
      end
      if (WE && A2 == REG_EPC) begin
        epc_d = {DIn[31:2], 2'b00};
      end
      if (EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= IM_RESET;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    case (A1)
      REG_SR:    DOut = sr_word(im_q, exl_q, ie_q);
      REG_CAUSE: DOut = cause_word(bd_q, ip_q, exc_code_q);
      REG_EPC:   DOut = epc_q;
      REG_PRID:  DOut = PRID_VAL;
      default:   DOut = 32'd0;
    endcase
  end

  assign EPCOut = epc_q;

endmodule
